cmd_arb: RTL and testbench

Arbitration and sequencing controller placed between the command sources (BLE/UART wrapper and tour move sequencer) and the single `cmd_proc` instance. Grants the shared command path to one requester at a time, presents the granted 16-bit command with a `cmd_rdy`/`clr_cmd_rdy` handshake, and schedules the 8-bit BLE responses back through the UART transmitter. A watchdog releases the path if `cmd_proc` never reports completion.

---
 rtl/cmd_arb_pkg.sv | 27 ++
 rtl/cmd_arb_resp_sched.sv | 103 ++++++++++
 rtl/cmd_arb.sv | 169 ++++++++++++++++
 tb/tb_cmd_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_arb_pkg.sv
// cmd_arb_pkg: shared types and default response codes for the command
// arbiter and its response scheduler.
package cmd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_EXEC,
    ST_RESP
  } main_st_e;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_st_e;

  typedef enum logic {
    OWN_UART,
    OWN_TOUR
  } owner_e;

  localparam int unsigned TMO_W_DEF     = 24;
  localparam logic [7:0]  RESP_DONE_DEF = 8'hA5;
  localparam logic [7:0]  RESP_PROG_DEF = 8'h5A;
  localparam logic [7:0]  RESP_ERR_DEF  = 8'h55;

endpackage

// File: rtl/cmd_arb_resp_sched.sv
// resp_sched: response byte scheduler in front of the UART transmitter.
// A pushed byte is launched (resp + one-cycle trmt) when the transmitter is
// idle, parked in a 1-deep hold register while it is busy, and dropped with
// the sticky resp_ovf flag set when the hold register is already occupied.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_push/i_byte : response byte to schedule (one-cycle strobe)
//   i_tx_done     : transmitter finished the current byte
//   o_resp/o_trmt : byte to transmit and its start pulse
//   o_resp_ovf    : sticky, a byte was dropped
module resp_sched
  import cmd_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_byte,
  input  logic       i_tx_done,
  output logic [7:0] o_resp,
  output logic       o_trmt,
  output logic       o_resp_ovf
);

  tx_st_e     r_state;
  tx_st_e     w_state_nxt;
  logic [7:0] r_hold;
  logic       r_hold_vld;
  logic [7:0] r_resp;
  logic       r_trmt;
  logic       r_ovf;

  logic       w_send;
  logic [7:0] w_send_byte;
  logic       w_hold_ld;
  logic       w_hold_clr;
  logic       w_ovf;

  always_comb begin
    w_state_nxt = r_state;
    w_send      = 1'b0;
    w_send_byte = i_byte;
    w_hold_ld   = 1'b0;
    w_hold_clr  = 1'b0;
    w_ovf       = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (i_push) begin
          w_send      = 1'b1;
          w_state_nxt = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (i_tx_done) begin
          if (r_hold_vld) begin
            // Held byte goes out first; a simultaneous push refills the hold.
            w_send      = 1'b1;
            w_send_byte = r_hold;
            if (i_push) w_hold_ld  = 1'b1;
            else        w_hold_clr = 1'b1;
          end else if (i_push) begin
            w_send = 1'b1;
          end else begin
            w_state_nxt = TX_IDLE;
          end
        end else if (i_push) begin
          if (r_hold_vld) w_ovf     = 1'b1;
          else            w_hold_ld = 1'b1;
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= TX_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_resp     <= '0;
      r_trmt     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_trmt <= w_send;
      if (w_send) r_resp <= w_send_byte;
      if (w_hold_ld) begin
        r_hold     <= i_byte;
        r_hold_vld <= 1'b1;
      end else if (w_hold_clr) begin
        r_hold_vld <= 1'b0;
      end
      if (w_ovf) r_ovf <= 1'b1;
    end
  end

  assign o_resp     = r_resp;
  assign o_trmt     = r_trmt;
  assign o_resp_ovf = r_ovf;

endmodule

// File: rtl/cmd_arb.sv
// cmd_arb: grants the shared cmd_proc command path to the tour sequencer or
// the UART wrapper, presents the command with a cmd_rdy/clr_cmd_rdy
// handshake, and queues the completion response towards the UART
// transmitter. A watchdog of TMO_W bits aborts a command that never
// completes and reports RESP_ERR.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   cmd_UART/cmd_rdy_UART/clr_UART: UART command source and consume pulse
//   tour_cmd/tour_vld/tour_last/tour_ack : tour move source and consume pulse
//   cmd/cmd_rdy/clr_cmd_rdy       : command handshake with cmd_proc
//   send_resp                     : cmd_proc completion strobe
//   resp/trmt/tx_done             : UART transmitter interface
//   resp_ovf                      : sticky, a response byte was dropped
module cmd_arb
  import cmd_arb_pkg::*;
#(
  parameter int unsigned TMO_W     = TMO_W_DEF,
  parameter logic [7:0]  RESP_DONE = RESP_DONE_DEF,
  parameter logic [7:0]  RESP_PROG = RESP_PROG_DEF,
  parameter logic [7:0]  RESP_ERR  = RESP_ERR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_UART,
  input  logic [15:0] tour_cmd,
  input  logic        tour_vld,
  input  logic        tour_last,
  output logic        tour_ack,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        trmt,
  input  logic        tx_done,
  output logic        resp_ovf
);

  main_st_e         r_state;
  main_st_e         w_state_nxt;
  owner_e           r_owner;
  logic             r_last;
  logic             r_in_tour;
  logic [15:0]      r_cmd;
  logic             r_cmd_rdy;
  logic             r_clr_uart;
  logic             r_tour_ack;
  logic [TMO_W-1:0] r_wdog;
  logic [7:0]       r_resp_byte;

  logic             w_grant_tour;
  logic             w_grant_uart;
  logic             w_enter_exec;
  logic             w_done;
  logic             w_tmo;
  logic             w_push;
  logic [7:0]       w_resp_sel;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_tour = 1'b0;
    w_grant_uart = 1'b0;
    w_enter_exec = 1'b0;
    w_done       = 1'b0;
    w_tmo        = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tour_vld) begin
          w_grant_tour = 1'b1;
          w_state_nxt  = ST_ISSUE;
        end else if (cmd_rdy_UART && !r_in_tour) begin
          w_grant_uart = 1'b1;
          w_state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (clr_cmd_rdy) begin
          // Completion reported together with acceptance skips EXEC.
          if (send_resp) begin
            w_done      = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_enter_exec = 1'b1;
            w_state_nxt  = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (send_resp) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (&r_wdog) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_push      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    if (w_tmo)                                  w_resp_sel = RESP_ERR;
    else if (r_owner == OWN_TOUR && !r_last)    w_resp_sel = RESP_PROG;
    else                                        w_resp_sel = RESP_DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= OWN_UART;
      r_last      <= 1'b0;
      r_in_tour   <= 1'b0;
      r_cmd       <= '0;
      r_cmd_rdy   <= 1'b0;
      r_clr_uart  <= 1'b0;
      r_tour_ack  <= 1'b0;
      r_wdog      <= '0;
      r_resp_byte <= '0;
    end else begin
      r_clr_uart <= w_grant_uart;
      r_tour_ack <= w_grant_tour;
      if (w_grant_tour) begin
        r_cmd     <= tour_cmd;
        r_owner   <= OWN_TOUR;
        r_last    <= tour_last;
        r_in_tour <= 1'b1;
      end else if (w_grant_uart) begin
        r_cmd   <= cmd_UART;
        r_owner <= OWN_UART;
        r_last  <= 1'b0;
      end
      if (w_grant_tour || w_grant_uart)          r_cmd_rdy <= 1'b1;
      else if (r_state == ST_ISSUE && clr_cmd_rdy) r_cmd_rdy <= 1'b0;
      if (w_enter_exec)             r_wdog <= '0;
      else if (r_state == ST_EXEC)  r_wdog <= r_wdog + 1'b1;
      if (w_done || w_tmo) r_resp_byte <= w_resp_sel;
      // A timeout aborts the whole tour, not just the current move.
      if (w_tmo || (w_done && r_owner == OWN_TOUR && r_last)) r_in_tour <= 1'b0;
    end
  end

  resp_sched u_resp_sched (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_byte     (r_resp_byte),
    .i_tx_done  (tx_done),
    .o_resp     (resp),
    .o_trmt     (trmt),
    .o_resp_ovf (resp_ovf)
  );

  assign cmd      = r_cmd;
  assign cmd_rdy  = r_cmd_rdy;
  assign clr_UART = r_clr_uart;
  assign tour_ack = r_tour_ack;

endmodule

// File: tb/tb_cmd_arb.sv
module tb_cmd_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_UART;
  logic [15:0] tour_cmd;
  logic        tour_vld;
  logic        tour_last;
  logic        tour_ack;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;
  logic        resp_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmd_arb #(.TMO_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .clr_UART     (clr_UART),
    .tour_cmd     (tour_cmd),
    .tour_vld     (tour_vld),
    .tour_last    (tour_last),
    .tour_ack     (tour_ack),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp         (resp),
    .trmt         (trmt),
    .tx_done      (tx_done),
    .resp_ovf     (resp_ovf)
  );

  typedef struct packed {
    logic        tv;
    logic        tl;
    logic [15:0] tc;
    logic        ur;
    logic [15:0] uc;
    logic        clr;
    logic        sr;
    logic        txd;
    logic [15:0] e_cmd;
    logic        e_rdy;
    logic        e_clru;
    logic        e_ack;
    logic        e_trmt;
    logic [7:0]  e_resp;
    logic        e_ovf;
  } vec_t;

  vec_t vec [15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_pulse();
    cyc();
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
  endtask

  // Request, accept and complete one command; t returns trmt in the cycle
  // two after send_resp.
  task automatic run(input logic is_tour, input logic [15:0] c, input logic last,
                     input logic split, output logic t);
    if (is_tour) begin
      tour_vld = 1'b1; tour_cmd = c; tour_last = last;
    end else begin
      cmd_rdy_UART = 1'b1; cmd_UART = c;
    end
    cyc();
    if (is_tour) tour_vld = 1'b0;
    else         cmd_rdy_UART = 1'b0;
    @(negedge clk);
    check("run.cmd", 32'(cmd), 32'(c));
    check("run.cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("run.grant", 32'(is_tour ? tour_ack : clr_UART), 32'd1);
    if (is_tour) check("run.no_clr_uart", 32'(clr_UART), 32'd0);
    clr_cmd_rdy = 1'b1;
    if (split) begin
      cyc();
      clr_cmd_rdy = 1'b0;
    end
    send_resp = 1'b1;
    cyc();
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    cyc();
    @(negedge clk);
    t = trmt;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic t;
    int   k;
    int   cnt;

    //             tv    tl    tc       ur    uc       clr   sr    txd   cmd      rdy   clru  ack   trmt  resp   ovf
    vec[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h2002, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h2002, 1'b0, 1'b0, 1'b0, 16'h2002, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h2002, 1'b1, 1'b0, 1'b0, 16'h2002, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h2002, 1'b0, 1'b1, 1'b0, 16'h2002, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h2002, 1'b0, 1'b0, 1'b0, 16'h2002, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h2002, 1'b0, 1'b0, 1'b0, 16'h2002, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h2002, 1'b0, 1'b0, 1'b1, 16'h2002, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h2002, 1'b0, 1'b0, 1'b0, 16'h2002, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vec[8]  = '{1'b1, 1'b0, 16'h3001, 1'b1, 16'h2ABC, 1'b0, 1'b0, 1'b0, 16'h2002, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 16'h3001, 1'b1, 16'h2ABC, 1'b0, 1'b0, 1'b0, 16'h3001, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
    vec[10] = '{1'b0, 1'b0, 16'h3001, 1'b1, 16'h2ABC, 1'b1, 1'b1, 1'b0, 16'h3001, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vec[11] = '{1'b0, 1'b0, 16'h3001, 1'b1, 16'h2ABC, 1'b0, 1'b0, 1'b0, 16'h3001, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vec[12] = '{1'b0, 1'b0, 16'h3001, 1'b1, 16'h2ABC, 1'b0, 1'b0, 1'b0, 16'h3001, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0};
    vec[13] = '{1'b0, 1'b0, 16'h3001, 1'b1, 16'h2ABC, 1'b0, 1'b0, 1'b1, 16'h3001, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0};
    vec[14] = '{1'b0, 1'b0, 16'h3001, 1'b1, 16'h2ABC, 1'b0, 1'b0, 1'b0, 16'h3001, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0};

    rst = 1'b1;
    cmd_UART = '0; cmd_rdy_UART = 1'b0; tour_cmd = '0; tour_vld = 1'b0;
    tour_last = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; tx_done = 1'b0;
    cyc();
    @(negedge clk);
    check("reset.cmd", 32'(cmd), 32'd0);
    check("reset.ctrl", 32'({cmd_rdy, clr_UART, tour_ack, trmt, resp_ovf}), 32'd0);
    check("reset.resp", 32'(resp), 32'd0);
    rst = 1'b0;
    cyc();

    // UART command, then simultaneous tour/UART request with the first tour move.
    for (int i = 0; i < 15; i++) begin
      tour_vld = vec[i].tv; tour_last = vec[i].tl; tour_cmd = vec[i].tc;
      cmd_rdy_UART = vec[i].ur; cmd_UART = vec[i].uc;
      clr_cmd_rdy = vec[i].clr; send_resp = vec[i].sr; tx_done = vec[i].txd;
      @(negedge clk);
      check($sformatf("v%0d.cmd", i), 32'(cmd), 32'(vec[i].e_cmd));
      check($sformatf("v%0d.cmd_rdy", i), 32'(cmd_rdy), 32'(vec[i].e_rdy));
      check($sformatf("v%0d.clr_UART", i), 32'(clr_UART), 32'(vec[i].e_clru));
      check($sformatf("v%0d.tour_ack", i), 32'(tour_ack), 32'(vec[i].e_ack));
      check($sformatf("v%0d.trmt", i), 32'(trmt), 32'(vec[i].e_trmt));
      check($sformatf("v%0d.resp", i), 32'(resp), 32'(vec[i].e_resp));
      check($sformatf("v%0d.resp_ovf", i), 32'(resp_ovf), 32'(vec[i].e_ovf));
      cyc();
    end
    tx_done = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;

    // Remaining tour moves with UART 2ABC still pending.
    run(1'b1, 16'h3002, 1'b0, 1'b1, t);
    check("tour2.trmt", 32'(t), 32'd1);
    check("tour2.resp", 32'(resp), 32'h5A);
    tx_pulse();
    run(1'b1, 16'h3003, 1'b1, 1'b1, t);
    check("tour3.trmt", 32'(t), 32'd1);
    check("tour3.resp", 32'(resp), 32'hA5);
    check("tour3.no_clr_uart", 32'(clr_UART), 32'd0);
    cyc();
    @(negedge clk);
    check("uart_after_tour.clr", 32'(clr_UART), 32'd1);
    check("uart_after_tour.cmd", 32'(cmd), 32'h2ABC);
    cmd_rdy_UART = 1'b0;
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    clr_cmd_rdy = 1'b1; send_resp = 1'b1;
    cyc();
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    cyc();
    @(negedge clk);
    check("uart_after_tour.trmt", 32'(trmt), 32'd1);
    check("uart_after_tour.resp", 32'(resp), 32'hA5);
    tx_pulse();

    // Watchdog timeout aborts the tour; the pending UART request then wins.
    tour_vld = 1'b1; tour_cmd = 16'h3100; tour_last = 1'b0;
    cmd_rdy_UART = 1'b1; cmd_UART = 16'h2BBB;
    cyc();
    tour_vld = 1'b0;
    @(negedge clk);
    check("tmo.ack", 32'(tour_ack), 32'd1);
    clr_cmd_rdy = 1'b1;
    cyc();
    clr_cmd_rdy = 1'b0;
    k = 0;
    cnt = 0;
    while (k < 40) begin
      @(negedge clk);
      if (clr_UART) cnt++;
      if (trmt) break;
      cyc();
      k++;
    end
    check("tmo.cycles", 32'(k), 32'd17);
    check("tmo.resp", 32'(resp), 32'h55);
    check("tmo.no_early_clr", 32'(cnt), 32'd0);
    cyc();
    @(negedge clk);
    check("tmo.uart_grant", 32'(clr_UART), 32'd1);
    check("tmo.uart_cmd", 32'(cmd), 32'h2BBB);
    cmd_rdy_UART = 1'b0;
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    clr_cmd_rdy = 1'b1; send_resp = 1'b1;
    cyc();
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    cyc();
    @(negedge clk);
    check("tmo.uart_trmt", 32'(trmt), 32'd1);
    check("tmo.uart_resp", 32'(resp), 32'hA5);
    tx_pulse();

    // Three completions with tx_done withheld: send, hold, drop.
    run(1'b0, 16'h2111, 1'b0, 1'b0, t);
    check("ovf.first_trmt", 32'(t), 32'd1);
    check("ovf.first_resp", 32'(resp), 32'hA5);
    run(1'b1, 16'h3200, 1'b0, 1'b0, t);
    check("ovf.held_trmt", 32'(t), 32'd0);
    check("ovf.held_flag", 32'(resp_ovf), 32'd0);
    run(1'b1, 16'h3201, 1'b1, 1'b0, t);
    check("ovf.drop_trmt", 32'(t), 32'd0);
    check("ovf.drop_flag", 32'(resp_ovf), 32'd1);
    cyc();
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    @(negedge clk);
    check("ovf.held_sent", 32'(trmt), 32'd1);
    check("ovf.held_resp", 32'(resp), 32'h5A);
    tx_pulse();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (trmt) cnt++;
      cyc();
    end
    check("ovf.no_dropped_send", 32'(cnt), 32'd0);
    check("ovf.sticky", 32'(resp_ovf), 32'd1);

    // Reset during EXEC with a byte held.
    run(1'b0, 16'h2400, 1'b0, 1'b0, t);
    check("rst.setup_trmt", 32'(t), 32'd1);
    run(1'b0, 16'h2401, 1'b0, 1'b0, t);
    cmd_rdy_UART = 1'b1; cmd_UART = 16'h2402;
    cyc();
    cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b1;
    cyc();
    clr_cmd_rdy = 1'b0;
    cyc();
    #1;
    rst = 1'b1;
    #1;
    check("rst.cmd", 32'(cmd), 32'd0);
    check("rst.resp", 32'(resp), 32'd0);
    check("rst.ovf", 32'(resp_ovf), 32'd0);
    check("rst.ctrl", 32'({cmd_rdy, clr_UART, tour_ack, trmt}), 32'd0);
    cyc();
    @(negedge clk);
    rst = 1'b0;
    tx_pulse();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (trmt) cnt++;
      cyc();
    end
    check("rst.no_trmt", 32'(cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
